// File: rtl/addsub_pkg.sv
// Shared width and FSM encodings for the add/subtract arbiter.
package addsub_pkg;

  localparam int WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit adder/subtractor; cobo is carry-out on add, no-borrow on subtract.
module addsub_unit #(
  parameter int WIDTH = addsub_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             cobo,
  output logic [WIDTH-1:0] sd
);

  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_res;

  // Subtract is a + ~b + 1, so the carry-in doubles as the mode bit.
  assign w_b_op = m ? ~b : b;
  assign w_res  = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, m};

  assign cobo = w_res[WIDTH];
  assign sd   = w_res[WIDTH-1:0];

endmodule

// File: rtl/addsub6_arbiter.sv
// Two-requester round-robin front end sharing one add/subtract unit, one op per 3 cycles.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and latches operands on the edge
//   EXEC  | gnt of the winner high; result loaded into sd/cobo on the edge
//   DONE  | done of the winner pulses for one cycle, then back to IDLE
module addsub6_arbiter #(
  parameter int WIDTH = addsub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             m0,
  input  logic             m1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] sd,
  output logic             cobo,
  output logic             busy
);

  import addsub_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_m;
  logic             r_gid;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_sd;
  logic             r_cobo;

  logic             w_any;
  logic             w_pick;
  logic [WIDTH-1:0] w_sd;
  logic             w_cobo;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  assign w_any  = req0 | req1;
  assign w_pick = (req0 & req1) ? ~r_last : req1;

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a    (r_a),
    .b    (r_b),
    .m    (r_m),
    .cobo (w_cobo),
    .sd   (w_sd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= 1'b0;
      r_gid   <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_sd    <= '0;
      r_cobo  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          if (w_any) begin
            r_gid   <= w_pick;
            r_last  <= w_pick;
            r_a     <= w_pick ? a1 : a0;
            r_b     <= w_pick ? b1 : b0;
            r_m     <= w_pick ? m1 : m0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_sd    <= w_sd;
          r_cobo  <= w_cobo;
          r_done0 <= ~r_gid;
          r_done1 <= r_gid;
          r_state <= DONE;
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign sd    = r_sd;
  assign cobo  = r_cobo;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_addsub6_arbiter.sv
// Directed bench for addsub6_arbiter: arithmetic, round-robin order, drops and resets.
module tb_addsub6_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [5:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       m0 = 1'b0, m1 = 1'b0;
  logic       gnt0, gnt1, done0, done1, cobo, busy;
  logic [5:0] sd;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  addsub6_arbiter #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .m0    (m0),
    .m1    (m1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .sd    (sd),
    .cobo  (cobo),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      check("done_excl", 32'(done0 & done1), 32'd0);
    end
  end

  // Waits (bounded) for gnt of id, then checks the done cycle and the return to IDLE.
  task automatic op(input int id, input logic [5:0] e_sd, input logic e_co, input bit drop,
                    output int lat, output int dcyc);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((id == 1) ? gnt1 : gnt0) !== 1'b1 && lat < 20);
    check("gnt_seen", 32'((id == 1) ? gnt1 : gnt0), 32'd1);
    check("gnt_other", 32'((id == 1) ? gnt0 : gnt1), 32'd0);
    check("busy_exec", 32'(busy), 32'd1);
    @(negedge clk);
    check("done", 32'((id == 1) ? done1 : done0), 32'd1);
    check("sd", 32'(sd), 32'(e_sd));
    check("cobo", 32'(cobo), 32'(e_co));
    check("gnt_off", 32'({gnt0, gnt1}), 32'd0);
    dcyc = cyc;
    if (drop) begin
      if (id == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'({done0, done1}), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, d0, d1, n;

    #3;
    check("rst_ctl", 32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_cobo", 32'(cobo), 32'd0);

    // 23 + 20, first request sampled at the first edge after release
    @(negedge clk);
    a0 = 6'd23; b0 = 6'd20; m0 = 1'b0; req0 = 1'b1;
    rst_n = 1'b1;
    op(0, 6'd43, 1'b0, 1'b1, lat, d0);
    check("lat_first", 32'(lat), 32'd1);

    // 53 - 10, then 23 - 40
    a1 = 6'd53; b1 = 6'd10; m1 = 1'b1; req1 = 1'b1;
    op(1, 6'd43, 1'b1, 1'b1, lat, d1);
    a1 = 6'd23; b1 = 6'd40; m1 = 1'b1; req1 = 1'b1;
    op(1, 6'd47, 1'b0, 1'b1, lat, d1);

    // Simultaneous requests straight out of reset: 0 first, then 1
    rst_n = 1'b0;
    a0 = 6'd56; b0 = 6'd42; m0 = 1'b0;
    a1 = 6'd30; b1 = 6'd63; m1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 6'd34, 1'b1, 1'b1, lat, d0);
    op(1, 6'd29, 1'b1, 1'b1, lat, d1);
    check("done_gap", 32'(d1 - d0), 32'd3);
    check("lat_second", 32'(lat), 32'd1);
    req0 = 1'b1; req1 = 1'b1;
    op(0, 6'd34, 1'b1, 1'b0, lat, d0);
    req0 = 1'b0;
    op(1, 6'd29, 1'b1, 1'b1, lat, d1);

    // Both held for six operations: strict alternation
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op(i % 2, (i % 2 == 1) ? 6'd29 : 6'd34, 1'b1, (i >= 4), lat, d0);
      check("rr_lat", 32'(lat), 32'd1);
    end

    // Reset during EXEC of 12 - 6 abandons the operation
    a0 = 6'd12; b0 = 6'd6; m0 = 1'b1; req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt0 !== 1'b1 && n < 20);
    check("rst_gnt_seen", 32'(gnt0), 32'd1);
    #1 rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("rst_mid_ctl", 32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
    check("rst_mid_sd", 32'(sd), 32'd0);
    check("rst_mid_cobo", 32'(cobo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'({done0, done1}), 32'd0);
      check("rst_idle", 32'(busy), 32'd0);
    end

    // req0 dropped during EXEC of 2 + 56 still completes
    a0 = 6'd2; b0 = 6'd56; m0 = 1'b0; req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt0 !== 1'b1 && n < 20);
    check("drop_gnt_seen", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(done0), 32'd1);
    check("drop_sd", 32'(sd), 32'd58);
    check("drop_cobo", 32'(cobo), 32'd0);
    @(negedge clk);
    check("drop_done_pulse", 32'(done0), 32'd0);
    check("drop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("drop_stay_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
